alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches one or two operands from a shared bus, then drives
// an external ALU for one cycle and latches its result and flags.
// Optional feature macro: ALU_SEQ_CHAIN_EN. When it is defined, a start with
// chain=1 takes operand A from the previous result and skips the A fetch.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             use_carry,
    input  logic             chain,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_valid,
    output logic             bus_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_select,
    output logic             alu_carry_in,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             alu_carry_out,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic             uc_q, uc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;

    // Invert, increment and decrement take a single operand.
    function automatic logic is_unary(input logic [2:0] code);
        return code >= 3'd5;
    endfunction

`ifndef ALU_SEQ_CHAIN_EN
    logic chain_unused;
    assign chain_unused = chain;
`endif

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        uc_d     = uc_q;
        result_d = result_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = op;
                    uc_d    = use_carry;
                    state_d = GET_A;
`ifdef ALU_SEQ_CHAIN_EN
                    if (chain) begin
                        a_d = result_q;
                        if (is_unary(op)) begin
                            b_d     = '0;
                            state_d = EXEC;
                        end else begin
                            state_d = GET_B;
                        end
                    end
`endif
                end
            end
            GET_A: begin
                if (bus_valid) begin
                    a_d = bus_in;
                    if (is_unary(sel_q)) begin
                        b_d     = '0;
                        state_d = EXEC;
                    end else begin
                        state_d = GET_B;
                    end
                end
            end
            GET_B: begin
                if (bus_valid) begin
                    b_d     = bus_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_data;
                cf_d     = alu_carry_out;
                zf_d     = alu_zero;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            uc_q     <= 1'b0;
            result_q <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            uc_q     <= uc_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        bus_ready    = (state_q == GET_A) || (state_q == GET_B);
        alu_enable   = (state_q == EXEC);
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        alu_a        = a_q;
        alu_b        = b_q;
        alu_select   = sel_q;
        alu_carry_in = uc_q & cf_q;
        result       = result_q;
        carry_flag   = cf_q;
        zero_flag    = zf_q;
    end

endmodule
